instr_fetch_unit: RTL and testbench

Instruction fetch stage for the RISC-V core; sits directly upstream of the main decoder. Holds the program counter and fetches one 32-bit instruction at a time from instruction memory over a req/ack handshake. Presents the instruction, its opcode field, and the PC to the decode stage until the core consumes it. Applies the next-PC selection (PC+4 or branch/jump target) supplied by the datapath.

---
 rtl/instr_fetch_unit_if.sv | 22 ++
 rtl/instr_fetch_unit.sv | 98 +++++++++
 tb/tb_instr_fetch_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory request/ack bus
// The fetch unit is the master; instruction memory is the slave.
interface instr_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RISC-V fetch stage: PC, one-deep instruction holding register
// Fetches one word per req/ack handshake and holds it for decode until advance.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                      clk,
   input  logic                      reset,
   instr_fetch_unit_if.master        imem,
   input  logic                      advance,
   input  logic                      pc_src,
   input  logic [31:0]               pc_target,
   output logic [31:0]               instr,
   output logic [6:0]                op,
   output logic [31:0]               pc,
   output logic [31:0]               pc_plus4,
   output logic                      instr_valid,
   output logic                      misaligned_err
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_VALID = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      err_d   = err_q;
      case (state_q)
         S_FETCH: begin
            if (imem.imem_ack) begin
               instr_d = imem.imem_rdata;
               valid_d = 1'b1;
               state_d = S_VALID;
            end
         end
         S_VALID: begin
            if (advance) begin
               instr_d = NOP_INSTR;
               valid_d = 1'b0;
               if (!pc_src) begin
                  pc_d    = pc_plus4;
                  state_d = S_FETCH;
               end else if (pc_target[1:0] == 2'b00) begin
                  pc_d    = pc_target;
                  state_d = S_FETCH;
               end else begin
                  // Misaligned target: park here with pc intact so the faulting branch can be inspected.
                  err_d   = 1'b1;
                  state_d = S_HALT;
               end
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   assign imem.imem_req  = (state_q == S_FETCH) & ~reset;
   assign imem.imem_addr = pc_q;
   assign pc             = pc_q;
   assign pc_plus4       = pc_q + 32'd4;
   assign instr          = instr_q;
   assign op             = instr_q[6:0];
   assign instr_valid    = valid_q;
   assign misaligned_err = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
// Inputs change and outputs are sampled on the falling edge.
module tb_instr_fetch_unit;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   instr_fetch_unit_if a_if ();
   instr_fetch_unit_if b_if ();

   logic        a_advance, a_pc_src;
   logic [31:0] a_pc_target;
   logic [31:0] a_instr, a_pc, a_pc_plus4;
   logic [6:0]  a_op;
   logic        a_valid, a_err;

   logic        b_advance, b_pc_src;
   logic [31:0] b_pc_target;
   logic [31:0] b_instr, b_pc, b_pc_plus4;
   logic [6:0]  b_op;
   logic        b_valid, b_err;

   instr_fetch_unit u_a (
      .clk            (clk),
      .reset          (reset),
      .imem           (a_if),
      .advance        (a_advance),
      .pc_src         (a_pc_src),
      .pc_target      (a_pc_target),
      .instr          (a_instr),
      .op             (a_op),
      .pc             (a_pc),
      .pc_plus4       (a_pc_plus4),
      .instr_valid    (a_valid),
      .misaligned_err (a_err)
   );

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_b (
      .clk            (clk),
      .reset          (reset),
      .imem           (b_if),
      .advance        (b_advance),
      .pc_src         (b_pc_src),
      .pc_target      (b_pc_target),
      .instr          (b_instr),
      .op             (b_op),
      .pc             (b_pc),
      .pc_plus4       (b_pc_plus4),
      .instr_valid    (b_valid),
      .misaligned_err (b_err)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset            = 1'b1;
      a_if.imem_ack    = 1'b0;
      a_if.imem_rdata  = 32'h0;
      a_advance        = 1'b0;
      a_pc_src         = 1'b0;
      a_pc_target      = 32'h0;
      b_if.imem_ack    = 1'b0;
      b_if.imem_rdata  = 32'h0;
      b_advance        = 1'b0;
      b_pc_src         = 1'b0;
      b_pc_target      = 32'h0;

      step();
      check_eq("rst_req",     {31'b0, a_if.imem_req}, 32'h0);
      check_eq("rst_pc",      a_pc, 32'h0);
      check_eq("rst_instr",   a_instr, 32'h0000_0013);
      check_eq("rst_valid",   {31'b0, a_valid}, 32'h0);
      check_eq("rst_err",     {31'b0, a_err}, 32'h0);
      check_eq("rst_b_pc",    b_pc, 32'hFFFF_FFFC);
      check_eq("rst_b_pc4",   b_pc_plus4, 32'h0);

      // ack during reset is discarded
      a_if.imem_ack   = 1'b1;
      a_if.imem_rdata = 32'hDEAD_BEEF;
      step();
      check_eq("rst_ack_valid", {31'b0, a_valid}, 32'h0);
      check_eq("rst_ack_instr", a_instr, 32'h0000_0013);

      a_if.imem_ack = 1'b0;
      reset         = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("wait_req",   {31'b0, a_if.imem_req}, 32'h1);
         check_eq("wait_addr",  a_if.imem_addr, 32'h0);
         check_eq("wait_valid", {31'b0, a_valid}, 32'h0);
      end

      a_if.imem_ack   = 1'b1;
      a_if.imem_rdata = 32'h0050_0093;
      step();
      a_if.imem_ack = 1'b0;
      check_eq("f0_instr", a_instr, 32'h0050_0093);
      check_eq("f0_op",    {25'b0, a_op}, 32'h13);
      check_eq("f0_valid", {31'b0, a_valid}, 32'h1);
      check_eq("f0_pc",    a_pc, 32'h0);
      check_eq("f0_pc4",   a_pc_plus4, 32'h4);
      check_eq("f0_req",   {31'b0, a_if.imem_req}, 32'h0);

      // stray ack while holding, no advance
      a_if.imem_ack   = 1'b1;
      a_if.imem_rdata = 32'hFFFF_FFFF;
      step();
      a_if.imem_ack = 1'b0;
      check_eq("stray_instr", a_instr, 32'h0050_0093);
      check_eq("stray_valid", {31'b0, a_valid}, 32'h1);

      a_advance = 1'b1;
      step();
      a_advance = 1'b0;
      check_eq("seq_pc",    a_pc, 32'h4);
      check_eq("seq_req",   {31'b0, a_if.imem_req}, 32'h1);
      check_eq("seq_addr",  a_if.imem_addr, 32'h4);
      check_eq("seq_valid", {31'b0, a_valid}, 32'h0);
      check_eq("seq_instr", a_instr, 32'h0000_0013);

      a_if.imem_ack   = 1'b1;
      a_if.imem_rdata = 32'h0000_0013;
      step();
      a_if.imem_ack = 1'b0;
      a_advance     = 1'b1;
      step();
      a_advance       = 1'b0;
      a_if.imem_ack   = 1'b1;
      a_if.imem_rdata = 32'h0000_0063;
      step();
      a_if.imem_ack = 1'b0;
      check_eq("pc8_pc",    a_pc, 32'h8);
      check_eq("pc8_valid", {31'b0, a_valid}, 32'h1);

      a_advance   = 1'b1;
      a_pc_src    = 1'b1;
      a_pc_target = 32'h40;
      step();
      a_advance = 1'b0;
      a_pc_src  = 1'b0;
      check_eq("br_addr", a_if.imem_addr, 32'h40);
      check_eq("br_req",  {31'b0, a_if.imem_req}, 32'h1);

      a_if.imem_ack   = 1'b1;
      a_if.imem_rdata = 32'h0000_006F;
      step();
      a_if.imem_ack = 1'b0;
      check_eq("br_op",  {25'b0, a_op}, 32'h6F);
      check_eq("br_pc",  a_pc, 32'h40);

      a_advance   = 1'b1;
      a_pc_src    = 1'b1;
      a_pc_target = 32'h42;
      step();
      a_advance = 1'b0;
      a_pc_src  = 1'b0;
      check_eq("mis_err",   {31'b0, a_err}, 32'h1);
      check_eq("mis_valid", {31'b0, a_valid}, 32'h0);
      a_if.imem_ack = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check_eq("halt_req", {31'b0, a_if.imem_req}, 32'h0);
         check_eq("halt_pc",  a_pc, 32'h40);
         check_eq("halt_err", {31'b0, a_err}, 32'h1);
      end
      a_if.imem_ack = 1'b0;

      reset = 1'b1;
      step();
      check_eq("halt_rst_err", {31'b0, a_err}, 32'h0);
      check_eq("halt_rst_pc",  a_pc, 32'h0);

      // ack present as reset falls is accepted in the first request cycle
      a_if.imem_ack   = 1'b1;
      a_if.imem_rdata = 32'h0000_0033;
      b_if.imem_ack   = 1'b1;
      b_if.imem_rdata = 32'h0000_0013;
      reset           = 1'b0;
      step();
      a_if.imem_ack = 1'b0;
      b_if.imem_ack = 1'b0;
      check_eq("rel_valid", {31'b0, a_valid}, 32'h1);
      check_eq("rel_instr", a_instr, 32'h0000_0033);
      check_eq("wrap_valid", {31'b0, b_valid}, 32'h1);
      check_eq("wrap_pc",    b_pc, 32'hFFFF_FFFC);
      check_eq("wrap_pc4",   b_pc_plus4, 32'h0);

      b_advance = 1'b1;
      step();
      b_advance = 1'b0;
      check_eq("wrap_next_pc", b_pc, 32'h0);
      check_eq("wrap_req",     {31'b0, b_if.imem_req}, 32'h1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
